// File: rtl/seg_demo_pkg.sv
// Shared definitions for the up/down counter 7-segment demo.
//   sel_state_t         : debouncer state encoding
//   DEBOUNCE_CYCLES_DEF : default stable interval (10 ms at 50 MHz)
//   CLK_HZ              : board clock frequency, shared with clk_div
package seg_demo_pkg;

  typedef enum logic [1:0] {
    S_RELEASED,
    S_ARM_PRESS,
    S_PRESSED,
    S_ARM_RELEASE
  } sel_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned CLK_HZ              = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports:
//   clk : destination clock
//   clr : synchronous active-high clear; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output, two edges behind d
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/select_debouncer.sv
// Debounces the display-select button and turns each accepted press into a
// toggle of the mux select line.
// Ports:
//   clk       : system clock
//   clr       : synchronous active-high reset
//   btn_raw   : raw bouncing button/switch input (asynchronous)
//   btn_level : debounced level, 1 = pressed
//   btn_pulse : one-cycle strobe per accepted press
//   select    : toggles on every accepted press
module select_debouncer
  import seg_demo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic select
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync_out;
  logic       pressed_s;
  sel_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       level_q;
  logic       pulse_q;
  logic       select_q;

  // Synchronizer resets to the raw "not pressed" level so no spurious press
  // is seen straight out of reset.
  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (btn_raw),
    .q   (sync_out)
  );

  assign pressed_s = sync_out ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_RELEASED;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      select_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        S_RELEASED: begin
          if (pressed_s) begin
            state_q <= S_ARM_PRESS;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        S_ARM_PRESS: begin
          if (!pressed_s) begin
            // Bounce: restart from scratch.
            state_q <= S_RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q  <= S_PRESSED;
            cnt_q    <= '0;
            level_q  <= 1'b1;
            pulse_q  <= 1'b1;
            select_q <= ~select_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PRESSED: begin
          if (!pressed_s) begin
            state_q <= S_ARM_RELEASE;
            cnt_q   <= CNT_W'(1);
          end
        end
        S_ARM_RELEASE: begin
          if (pressed_s) begin
            state_q <= S_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= S_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign select    = select_q;

endmodule

// File: tb/tb_select_debouncer.sv
// Bench for select_debouncer with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Table of per-edge vectors for reset, clean press and release, followed by
// hand-written sequences for bounce, glitch, repeated presses and mid-count reset.
module tb_select_debouncer;
  import seg_demo_pkg::*;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic clr;
  logic btn_raw;
  logic btn_level;
  logic btn_pulse;
  logic select;

  always #5 clk = ~clk;

  select_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .select    (select)
  );

  typedef struct {
    logic clr;
    logic raw;
    logic exp_level;
    logic exp_pulse;
    logic exp_select;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_no = 0;
  int   pulses = 0;
  int   last_pulse_edge = -1;

  task automatic add_vec(input logic c, input logic r, input logic l, input logic p,
                         input logic s, input int reps);
    vec_t v;
    v.clr = c; v.raw = r; v.exp_level = l; v.exp_pulse = p; v.exp_select = s;
    for (int k = 0; k < reps; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (btn_pulse === 1'b1) begin
      pulses++;
      last_pulse_edge = edge_no;
    end
  endtask

  task automatic hold(input logic r, input int n);
    btn_raw = r;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int e0;
    clr     = 1'b1;
    btn_raw = 1'b0;

    // Vector i drives inputs before edge i; outputs expected just after it.
    add_vec(1, 0, 0, 0, 0, 3);   // reset with button physically held
    add_vec(0, 1, 0, 0, 0, 4);   // released, sync settles
    add_vec(0, 0, 0, 0, 0, 5);   // press: edges 7..11 still counting
    add_vec(0, 0, 1, 1, 1, 1);   // edge 12 = 5 edges after change: pulse
    add_vec(0, 0, 1, 0, 1, 3);   // held
    add_vec(0, 1, 1, 0, 1, 5);   // release counting, level still 1
    add_vec(0, 1, 0, 0, 1, 5);   // released, no pulse, select stays 1

    for (int i = 0; i < vecs.size(); i++) begin
      clr     = vecs[i].clr;
      btn_raw = vecs[i].raw;
      tick();
      check($sformatf("vec%0d", i), {5'b0, btn_level, btn_pulse, select},
            {5'b0, vecs[i].exp_level, vecs[i].exp_pulse, vecs[i].exp_select});
      if (i == 2) check("reset_state", {6'b0, dut.state_q}, {6'b0, S_RELEASED});
    end

    // Bounce then stable press: one pulse 5 edges after final stable 0.
    pulses = 0;
    hold(0, 1); hold(1, 1); hold(0, 1); hold(1, 1);
    e0 = edge_no + 1;
    check("bounce_no_early_pulse", 8'(pulses), 8'd0);
    hold(0, 10);
    check("bounce_pulse_count", 8'(pulses), 8'd1);
    check("bounce_pulse_edge", 8'(last_pulse_edge - e0), 8'(D + 1));
    check("bounce_level_select", {6'b0, btn_level, select}, {6'b0, 1'b1, 1'b0});

    pulses = 0;
    hold(1, 12);
    check("release_no_pulse", 8'(pulses), 8'd0);
    check("release_level_select", {6'b0, btn_level, select}, {6'b0, 1'b0, 1'b0});

    // Two-cycle glitch is below the interval.
    pulses = 0;
    hold(0, 2);
    hold(1, 12);
    check("glitch_pulses", 8'(pulses), 8'd0);
    check("glitch_level_select", {6'b0, btn_level, select}, {6'b0, 1'b0, 1'b0});

    // Three press/release pairs: select 1,0,1.
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      hold(0, 12);
      check($sformatf("rep%0d_pressed", p), {6'b0, btn_level, select},
            {6'b0, 1'b1, ((p % 2) == 0) ? 1'b1 : 1'b0});
      hold(1, 12);
      check($sformatf("rep%0d_released", p), {6'b0, btn_level, select},
            {6'b0, 1'b0, ((p % 2) == 0) ? 1'b1 : 1'b0});
    end
    check("rep_pulse_count", 8'(pulses), 8'd3);

    // Reset two cycles into S_ARM_PRESS with the button held.
    pulses = 0;
    hold(0, 4);
    check("midrst_armed", {6'b0, dut.state_q}, {6'b0, S_ARM_PRESS});
    clr = 1'b1;
    tick();
    check("midrst_outputs", {5'b0, btn_level, btn_pulse, select}, 8'd0);
    check("midrst_state", {6'b0, dut.state_q}, {6'b0, S_RELEASED});
    clr = 1'b0;
    e0 = edge_no + 1;
    hold(0, 12);
    check("midrst_pulse_count", 8'(pulses), 8'd1);
    check("midrst_pulse_edge", 8'(last_pulse_edge - e0), 8'(D + 1));
    check("midrst_level_select", {6'b0, btn_level, select}, {6'b0, 1'b1, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
